// File: rtl/ls_pilot_estimator.sv
// Least-squares channel estimate over four QPSK pilot REs, collected in arrival order
// and held until the interpolation stage acknowledges them.
module ls_pilot_estimator #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 17
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        pil_valid,
    input  logic signed [IN_WIDTH-1:0]  pil_r,
    input  logic signed [IN_WIDTH-1:0]  pil_i,
    input  logic [1:0]                  pil_code,
    input  logic                        est_ack,
    output logic signed [OUT_WIDTH-1:0] E1_r,
    output logic signed [OUT_WIDTH-1:0] E1_i,
    output logic signed [OUT_WIDTH-1:0] E2_r,
    output logic signed [OUT_WIDTH-1:0] E2_i,
    output logic signed [OUT_WIDTH-1:0] E3_r,
    output logic signed [OUT_WIDTH-1:0] E3_i,
    output logic signed [OUT_WIDTH-1:0] E4_r,
    output logic signed [OUT_WIDTH-1:0] E4_i,
    output logic                        est_valid,
    output logic                        busy,
    output logic                        overrun
);

    if (OUT_WIDTH != IN_WIDTH + 1) begin : g_bad_width
        $error("OUT_WIDTH must equal IN_WIDTH+1");
    end

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StHold    = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       est_valid_q, est_valid_d;
    logic       overrun_q, overrun_d;

    logic signed [OUT_WIDTH-1:0] e_r_q [4];
    logic signed [OUT_WIDTH-1:0] e_r_d [4];
    logic signed [OUT_WIDTH-1:0] e_i_q [4];
    logic signed [OUT_WIDTH-1:0] e_i_d [4];

    logic signed [OUT_WIDTH-1:0] ext_r, ext_i;
    logic signed [OUT_WIDTH-1:0] r_xr, i_xi, i_xr, r_xi;
    logic signed [OUT_WIDTH-1:0] est_r, est_i;

    // Multiplying by +/-1 reduces to optional negation of the sign-extended operand.
    always_comb begin
        ext_r = OUT_WIDTH'(pil_r);
        ext_i = OUT_WIDTH'(pil_i);
        r_xr  = pil_code[0] ? -ext_r : ext_r;
        i_xr  = pil_code[0] ? -ext_i : ext_i;
        i_xi  = pil_code[1] ? -ext_i : ext_i;
        r_xi  = pil_code[1] ? -ext_r : ext_r;
        est_r = r_xr + i_xi;
        est_i = i_xr - r_xi;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        est_valid_d = est_valid_q;
        overrun_d   = overrun_q;
        e_r_d       = e_r_q;
        e_i_d       = e_i_q;
        if (start) begin
            // Restart wins over everything, including a coincident pilot or ack.
            state_d     = StCollect;
            cnt_d       = 2'd0;
            est_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            case (state_q)
                StCollect: begin
                    if (pil_valid) begin
                        e_r_d[cnt_q] = est_r;
                        e_i_d[cnt_q] = est_i;
                        cnt_d        = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d     = StHold;
                            est_valid_d = 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (pil_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (est_ack) begin
                        state_d     = StIdle;
                        est_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            est_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                e_r_q[k] <= '0;
                e_i_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            est_valid_q <= est_valid_d;
            overrun_q   <= overrun_d;
            e_r_q       <= e_r_d;
            e_i_q       <= e_i_d;
        end
    end

    assign E1_r      = e_r_q[0];
    assign E1_i      = e_i_q[0];
    assign E2_r      = e_r_q[1];
    assign E2_i      = e_i_q[1];
    assign E3_r      = e_r_q[2];
    assign E3_i      = e_i_q[2];
    assign E4_r      = e_r_q[3];
    assign E4_i      = e_i_q[3];
    assign est_valid = est_valid_q;
    assign busy      = (state_q == StCollect);
    assign overrun   = overrun_q;

endmodule
